// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, lane helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

  // RV32I load/store size codes (FUNCT3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP,
    ST_FAULT
  } lsu_state_t;

  // Stores only have B/H/W; loads add BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      F3_H, F3_HU: return lane[0];
      F3_W:        return (lane != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  function automatic logic [15:0] get_half(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extract+extend a load lane from a memory word; merge a store lane into a word.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: i_word memory word, i_lane byte offset, i_funct3 size code, i_wdata right-aligned
//        store data; o_load extended load result, o_store word to write back.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [4:0]  w_sh;

  assign w_byte = get_byte(i_word, i_lane);
  assign w_half = get_half(i_word, i_lane[1]);
  assign w_sh   = {i_lane, 3'b000};

  always_comb begin
    o_load  = i_word;
    o_store = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_load  = {{24{w_byte[7]}}, w_byte};
        o_store = (i_word & ~(32'h0000_00FF << w_sh)) | ({24'h0, i_wdata[7:0]} << w_sh);
      end
      F3_H: begin
        o_load  = {{16{w_half[15]}}, w_half};
        o_store = i_lane[1] ? {i_wdata[15:0], i_word[15:0]} : {i_word[31:16], i_wdata[15:0]};
      end
      F3_BU:   o_load = {24'h0, w_byte};
      F3_HU:   o_load = {16'h0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator: one core request -> DataMemory word accesses with RMW for sub-word stores.
// Latency: fault 1, load 2, SW 2, SB/SH 3 cycles from accepting edge to DONE.
// Backpressure: o_busy high while a request is in flight; requests seen while busy are dropped.
// Ports: i_req/i_is_store/i_funct3/i_addr/i_wdata request; o_busy/o_done/o_err/o_rdata
//        response; o_mem_we/o_mem_a/o_mem_wd/i_mem_rd DataMemory word port.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS   = 128,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_is_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_mem_we,
  output logic [31:0] o_mem_a,
  output logic [31:0] o_mem_wd,
  input  logic [31:0] i_mem_rd
);

  localparam logic [32:0] L_LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_t  r_state, w_next;
  logic        r_is_store;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_fault;
  logic [31:0] w_load;
  logic [31:0] w_store;

  assign w_fault = f3_illegal(i_is_store, i_funct3)
                 | f3_misaligned(i_funct3, i_addr[1:0])
                 | (CHECK_RANGE && ({1'b0, i_addr} >= L_LIMIT));

  lsu_align u_align (
    .i_word   (i_mem_rd),
    .i_lane   (r_lane),
    .i_funct3 (r_f3),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_store  (w_store)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    o_busy   = (r_state != ST_IDLE);
    o_done   = 1'b0;
    // Reset gates the strobe combinationally so a write caught mid-flight never lands.
    o_mem_we = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          if (w_fault)                              w_next = ST_FAULT;
          else if (i_is_store && i_funct3 == F3_W)  w_next = ST_WRITE;
          else                                      w_next = ST_READ;
        end
      end
      ST_READ:  w_next = r_is_store ? ST_WRITE : ST_RESP;
      ST_WRITE: begin
        o_mem_we = ~i_rst;
        w_next   = ST_RESP;
      end
      ST_RESP: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      ST_FAULT: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Response and memory-port registers hold their values between requests.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_store <= 1'b0;
      r_f3       <= 3'b000;
      r_lane     <= 2'b00;
      r_wdata    <= 32'h0;
      r_mem_a    <= 32'h0;
      r_mem_wd   <= 32'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_is_store <= i_is_store;
            r_f3       <= i_funct3;
            r_lane     <= i_addr[1:0];
            r_wdata    <= i_wdata;
            if (w_fault) begin
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
            end else begin
              r_mem_a <= {i_addr[31:2], 2'b00};
              if (w_next == ST_WRITE) r_mem_wd <= i_wdata;
            end
          end
        end
        ST_READ: begin
          if (r_is_store) begin
            r_mem_wd <= w_store;
          end else begin
            r_rdata <= w_load;
            r_err   <= 1'b0;
          end
        end
        ST_WRITE: begin
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_err    = r_err;
  assign o_rdata  = r_rdata;
  assign o_mem_a  = r_mem_a;
  assign o_mem_wd = r_mem_wd;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random requests against a byte-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_unit;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst, req, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(128), .CHECK_RANGE(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_is_store(is_store), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_err(err),
    .o_rdata(rdata), .o_mem_we(mem_we), .o_mem_a(mem_a), .o_mem_wd(mem_wd), .i_mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[8:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[8:2]] <= mem_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-level reference: decides fault, latency, load value and new memory word.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic flt, output int lat,
                       output logic [31:0] exp_rd, output logic [31:0] exp_wd);
    logic [7:0] by [4];
    int size, off, idx;
    logic legal;
    logic [31:0] val;
    idx = int'(a[8:2]);
    off = int'(a % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    flt = !legal || ((a % size) != 0) || (a >= 32'd512);
    exp_rd = 32'h0;
    exp_wd = 32'h0;
    lat = 1;
    if (!flt) begin
      for (int i = 0; i < 4; i++) by[i] = ref_mem[idx][8*i +: 8];
      if (!st) begin
        lat = 2;
        val = 32'h0;
        for (int k = 0; k < size; k++) val = val | (32'(by[off + k]) << (8 * k));
        if (!f3[2] && size < 4 && val[8*size - 1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
        exp_rd = val;
      end else begin
        lat = (size == 4) ? 2 : 3;
        for (int k = 0; k < size; k++) by[off + k] = wd[8*k +: 8];
        exp_wd = {by[3], by[2], by[1], by[0]};
        ref_mem[idx] = exp_wd;
      end
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got_rd);
    logic flt, seen;
    int lat, cyc, we_cnt;
    logic [31:0] e_rd, e_wd;
    model(st, f3, a, wd, flt, lat, e_rd, e_wd);
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    cyc = 0; we_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      req = 1'b0;
      if (mem_we) begin
        we_cnt++;
        check("mem_wd", mem_wd, e_wd);
        check("mem_a", mem_a, {a[31:2], 2'b00});
      end
      if (done) begin
        seen = 1'b1;
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(lat));
    check("err", 32'(err), 32'(flt));
    check("rdata", rdata, e_rd);
    check("we_pulses", 32'(we_cnt), (flt || !st) ? 32'd0 : 32'd1);
    check("mem_word", mem[a[8:2]], ref_mem[a[8:2]]);
    got_rd = rdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old, e_rd, e_wd;
    logic flt;
    int lat, dones, d1, d2;

    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    rst = 1'b0;

    // Word and sub-word loads
    mem[2] = 32'hDEADBEEF; ref_mem[2] = mem[2];
    do_req(1'b0, W, 32'h08, 32'h0, rd);  check("lw", rd, 32'hDEADBEEF);
    mem[2] = 32'h80FF7F01; ref_mem[2] = mem[2];
    do_req(1'b0, B, 32'h0B, 32'h0, rd);  check("lb", rd, 32'hFFFFFF80);
    do_req(1'b0, BU, 32'h0B, 32'h0, rd); check("lbu", rd, 32'h00000080);
    do_req(1'b0, H, 32'h0A, 32'h0, rd);  check("lh", rd, 32'hFFFF80FF);
    do_req(1'b0, HU, 32'h08, 32'h0, rd); check("lhu", rd, 32'h00007F01);

    // Sub-word stores
    mem[1] = 32'h11223344; ref_mem[1] = mem[1];
    do_req(1'b1, B, 32'h05, 32'hAA, rd);   check("sb_mem", mem[1], 32'h1122AA44);
    do_req(1'b1, H, 32'h06, 32'hBEEF, rd); check("sh_mem", mem[1], 32'hBEEFAA44);

    // Faults
    do_req(1'b0, W, 32'h02, 32'h0, rd);
    do_req(1'b0, H, 32'h01, 32'h0, rd);
    do_req(1'b0, 3'b011, 32'h04, 32'h0, rd);
    do_req(1'b1, W, 32'h200, 32'hCAFEF00D, rd);
    do_req(1'b1, BU, 32'h04, 32'h55, rd);

    // REQ held high across an SB: second request accepted only in the first IDLE cycle
    model(1'b1, B, 32'h15, 32'h000000C3, flt, lat, e_rd, e_wd);
    model(1'b0, W, 32'h14, 32'h0, flt, lat, e_rd, e_wd);
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = B; addr = 32'h15; wdata = 32'h000000C3;
    dones = 0; d1 = 0; d2 = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin is_store = 1'b0; funct3 = W; addr = 32'h14; end
      if (c == 4) check("busy_idle_gap", 32'(busy), 32'd0);
      if (c == 5) req = 1'b0;
      if (done) begin
        dones++;
        if (dones == 1) d1 = c;
        else begin
          d2 = c;
          check("busy_second_rdata", rdata, e_rd);
        end
      end
    end
    check("busy_done_count", 32'(dones), 32'd2);
    check("busy_first_done", 32'(d1), 32'd3);
    check("busy_second_done", 32'(d2), 32'd6);

    // Reset during the WRITE cycle of an SW
    old = mem[4];
    @(negedge clk);
    req = 1'b1; is_store = 1'b1; funct3 = W; addr = 32'h10; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    check("we_before_rst", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1 check("we_during_rst", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_mem_wd", mem_wd, 32'h0);
    check("arst_mem4", mem[4], old);
    @(negedge clk);
    check("arst_no_done", 32'(done), 32'd0);
    do_req(1'b0, W, 32'h10, 32'h0, rd);
    check("lw_after_rst", rd, old);

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 511));
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
